// File: rtl/adbg_or1k_ctrl_reg_if.sv
// Command-decoder side of the per-core debug control register:
// write strobe, write data and readback.
interface adbg_or1k_ctrl_reg_if #(
    parameter int unsigned NB_CORES = 4
);
    logic                      we_i;
    logic [NB_CORES*5-1:0]     data_i;
    logic [NB_CORES*6-1:0]     ctrl_reg_o;

    // Decoder drives writes and reads back state
    modport master (output we_i, output data_i, input ctrl_reg_o);
    // Control register consumes writes and presents state
    modport slave  (input we_i, input data_i, output ctrl_reg_o);
endinterface

// File: rtl/adbg_or1k_ctrl_reg.sv
// Per-core OR1K debug stall/reset/step control register, TCK domain only.
// Breakpoint stall is combinational so a hit halts the core in the same cycle;
// all other state is held in flops updated on tck_i.
module adbg_or1k_ctrl_reg #(
    parameter int unsigned NB_CORES    = 4,
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned RST_CW      = 4,
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned STEP_CW     = 2
) (
    input  logic                    tck_i,
    input  logic                    tlr_i,
    adbg_or1k_ctrl_reg_if.slave     bus,
    input  logic [NB_CORES-1:0]     bp_i,
    output logic [NB_CORES-1:0]     cpu_stall_o,
    output logic [NB_CORES-1:0]     cpu_rst_o
);

    localparam int unsigned WR_W = 5;
    localparam int unsigned RD_W = 6;

    // Reject parameter sets the counters cannot represent
    if (NB_CORES < 1 || RST_CW < 1 || RST_CW > 31 || STEP_CW < 1 || STEP_CW > 31 ||
        RST_CYCLES < 1 || RST_CYCLES > (2**RST_CW) - 1 ||
        STEP_CYCLES < 1 || STEP_CYCLES > (2**STEP_CW) - 1) begin : g_bad_param
        $fatal(1, "adbg_or1k_ctrl_reg: illegal parameter value");
    end

    typedef enum logic {S_IDLE = 1'b0, S_STEP = 1'b1} step_state_e;

    logic [NB_CORES-1:0] stall_reg;
    logic [NB_CORES-1:0] group_en;
    logic [NB_CORES-1:0] bp_hit;
    logic [RST_CW-1:0]   rst_cnt    [NB_CORES];
    logic [STEP_CW-1:0]  step_cnt   [NB_CORES];
    step_state_e         step_state [NB_CORES];

    logic [NB_CORES-1:0] rst_busy;
    logic [NB_CORES-1:0] step_busy;
    logic [NB_CORES-1:0] bpm;
    logic [NB_CORES-1:0] ev;
    logic                grp;
    logic [NB_CORES-1:0] d_stall, d_rst, d_step, d_grp, d_clr;
    logic [NB_CORES*RD_W-1:0] ctrl_reg;

    // Split write data into per-field vectors and decode busy flags from state
    always_comb begin
        d_stall   = '0;
        d_rst     = '0;
        d_step    = '0;
        d_grp     = '0;
        d_clr     = '0;
        rst_busy  = '0;
        step_busy = '0;
        for (int unsigned n = 0; n < NB_CORES; n++) begin
            d_stall[n]   = bus.data_i[n*WR_W + 0];
            d_rst[n]     = bus.data_i[n*WR_W + 1];
            d_step[n]    = bus.data_i[n*WR_W + 2];
            d_grp[n]     = bus.data_i[n*WR_W + 3];
            d_clr[n]     = bus.data_i[n*WR_W + 4];
            rst_busy[n]  = (rst_cnt[n] != '0);
            step_busy[n] = (step_state[n] == S_STEP);
        end
    end

    // Breakpoint masking, halt-group fan-out and the stall request
    always_comb begin
        bpm         = bp_i & ~rst_busy;
        grp         = |(bpm & group_en);
        ev          = bpm | ({NB_CORES{grp}} & group_en);
        cpu_stall_o = ev | (stall_reg & ~step_busy);
    end

    // Readback image of every core slice
    always_comb begin
        ctrl_reg = '0;
        for (int unsigned n = 0; n < NB_CORES; n++) begin
            ctrl_reg[n*RD_W +: RD_W] = {cpu_stall_o[n], bp_hit[n], group_en[n],
                                        step_busy[n], rst_busy[n], stall_reg[n]};
        end
    end

    assign bus.ctrl_reg_o = ctrl_reg;
    assign cpu_rst_o      = rst_busy;

    // Per-core stall, flags, reset pulse counter and step FSM
    always_ff @(posedge tck_i) begin
        if (tlr_i) begin
            stall_reg <= '0;
            group_en  <= '0;
            bp_hit    <= '0;
            for (int unsigned n = 0; n < NB_CORES; n++) begin
                rst_cnt[n]    <= '0;
                step_cnt[n]   <= '0;
                step_state[n] <= S_IDLE;
            end
        end else begin
            if (bus.we_i) begin
                group_en <= d_grp;
            end
            for (int unsigned n = 0; n < NB_CORES; n++) begin
                // A breakpoint event always wins over a host stall write
                if (ev[n]) begin
                    stall_reg[n] <= 1'b1;
                end else if (bus.we_i) begin
                    stall_reg[n] <= d_stall[n];
                end

                // Only a core's own breakpoint marks it as hit
                if (bpm[n]) begin
                    bp_hit[n] <= 1'b1;
                end else if (bus.we_i && d_clr[n]) begin
                    bp_hit[n] <= 1'b0;
                end

                // Reset pulse: a new go reloads, otherwise count down to zero
                if (bus.we_i && d_rst[n]) begin
                    rst_cnt[n] <= RST_CW'(RST_CYCLES);
                end else if (rst_cnt[n] != '0) begin
                    rst_cnt[n] <= rst_cnt[n] - RST_CW'(1);
                end

                case (step_state[n])
                    S_IDLE: begin
                        if (bus.we_i && d_step[n] && d_stall[n] && stall_reg[n] &&
                            !rst_busy[n] && !ev[n]) begin
                            step_state[n] <= S_STEP;
                            step_cnt[n]   <= STEP_CW'(STEP_CYCLES);
                        end
                    end
                    S_STEP: begin
                        if (ev[n] || step_cnt[n] <= STEP_CW'(1)) begin
                            step_state[n] <= S_IDLE;
                            step_cnt[n]   <= '0;
                        end else begin
                            step_cnt[n] <= step_cnt[n] - STEP_CW'(1);
                        end
                    end
                    default: begin
                        step_state[n] <= S_IDLE;
                        step_cnt[n]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/adbg_or1k_ctrl_reg.md
Name: adbg_or1k_ctrl_reg

Overview:
Parametrised successor to the per-core OR1K debug stall/reset control register, running entirely in the TCK domain. Each core has a write/read control slice with the following features:
- stall that is set by a breakpoint and cleared only by the host
- self-timed CPU reset pulse of programmable length
- single-step (timed stall release)
- sticky breakpoint-hit flag
- optional halt group: a breakpoint on any group member stalls every member

Sits between the debug-module command decoder and the CPU-side synchronizers. bp_i arrives already synchronized to tck_i.

Parameters:
NB_CORES, 4, number of controlled cores.
RST_CYCLES, 8, cpu_rst_o pulse length in tck_i cycles (1..2**RST_CW-1).
RST_CW, 4, reset pulse counter width.
STEP_CYCLES, 1, cycles cpu_stall_o is released per step (1..2**STEP_CW-1).
STEP_CW, 2, step counter width.

Ports:
tck_i  in  1  clock. Single clock; all state is updated on the rising edge.
tlr_i  in  1  reset. Synchronous, active-high.
we_i  in  1  write strobe, one cycle per write.
data_i  in  NB_CORES*5  per core slice [n*5 +: 5]: b0 stall, b1 rst_go, b2 step_go, b3 group_en, b4 bp_clr (write-1-to-clear).
ctrl_reg_o  out  NB_CORES*6  per core slice [n*6 +: 6]: b0 stall_reg, b1 rst_busy, b2 step_busy, b3 group_en, b4 bp_hit, b5 cpu_stall_o[n].
bp_i  in  NB_CORES  breakpoint, level, already in the tck_i domain.
cpu_stall_o  out  NB_CORES  stall request to the CPU synchronizer.
cpu_rst_o  out  NB_CORES  reset request to the CPU synchronizer.

Behaviour:
- Synchronous reset (tlr_i=1 at an edge): stall_reg, group_en, bp_hit, both counters all 0. Hence cpu_rst_o=0, cpu_stall_o=bp_i-driven only, ctrl_reg_o=0 apart from b5. Reset overrides every other event in the same cycle.
- Masked breakpoint: bpm[n] = bp_i[n] & ~rst_busy[n]. Breakpoints are ignored while a core is in reset.
- Group event: grp = |(bpm & group_en).
- Breakpoint event for core n: ev[n] = bpm[n] | (grp & group_en[n]).
- Stall register priority: tlr_i > ev[n] (stall_reg<=1) > we_i (stall_reg<=data b0). A write of stall=0 in the same cycle as ev loses. Other fields of that write still take effect.
- bp_hit: set by bpm[n] only (not by the group event). Cleared by we_i with b4=1. Set wins over a simultaneous clear.
- group_en: loaded from b3 on every we_i.
- Reset pulse:
  - we_i with b1=1 loads rst_cnt=RST_CYCLES. Writing 1 while busy reloads the counter (extends the pulse). Writing b1=0 never cancels a pulse.
  - Counter decrements each cycle while nonzero.
  - rst_busy = cpu_rst_o[n] = (rst_cnt!=0), registered. First high cycle is the cycle after the write; high for exactly RST_CYCLES cycles.
  - stall_reg is unaffected by the reset pulse.
- Per-core step FSM:
  - IDLE->STEP: on we_i with b2=1 and b0=1, when stall_reg=1, rst_busy=0 and no ev this cycle. Loads step_cnt=STEP_CYCLES.
  - STEP: step_cnt decrements each cycle; STEP->IDLE when it reaches 0.
  - STEP->IDLE immediately on ev (breakpoint abort), with step_cnt<=0.
  - step_go is ignored when the entry conditions fail, and ignored while already in STEP.
  - step_busy = (state==STEP).
- Stall output (combinational, so a breakpoint stalls in the same cycle):
  cpu_stall_o[n] = ev[n] | (stall_reg[n] & ~step_busy[n]).
  Step release is therefore exactly STEP_CYCLES cycles, starting the cycle after the write.
- Readback: ctrl_reg_o reflects register state after the edge. No read side effects.
- Width rules: counters saturate at 0 and never wrap. Parameter values outside the stated ranges are illegal; guard them with an elaboration assertion.

Test Plan:
1. Breakpoint latch: tlr_i pulse, then bp_i=4'b0010 for 1 cycle -> cpu_stall_o[1]=1 in the same cycle and stays 1; ctrl_reg_o[6 +: 6]=6'b110001. A write with data_i stall=0 on core 1 -> cpu_stall_o[1]=0 the next cycle; bp_hit stays 1 until a write with b4=1.
2. Reset pulse: write rst_go on core 0 at cycle t -> cpu_rst_o[0]=1 for cycles t+1..t+8 (RST_CYCLES=8). Rewrite rst_go at t+5 -> pulse extends through t+13. bp_i[0] asserted during the pulse -> no stall, no bp_hit.
3. Single-step: core 2 stalled; write b0=1,b2=1 -> cpu_stall_o[2]=0 for exactly 1 cycle, then 1; step_busy reads 1 during the release. Repeat with stall_reg=0 -> step ignored, step_busy stays 0.
4. Step abort: STEP_CYCLES=3; bp_i[2] asserted during the second release cycle -> cpu_stall_o[2]=1 that same cycle; FSM returns to IDLE; bp_hit[2]=1.
5. Halt group: group_en=4'b1011, bp_i=4'b0001 -> stall_reg=4'b1011 next cycle; cpu_stall_o[2]=0; bp_hit only on core 0.
6. Collisions: same cycle as bp_i[3], we_i with stall=0 and bp_clr=1 on core 3 -> stall_reg[3]=1, bp_hit[3]=1. tlr_i together with we_i rst_go -> all state 0, cpu_rst_o=0.
